// File: rtl/tristate_pkg.sv
// Shared definitions for the tristate bus arbiter and its buffers:
// FSM state type, a constant-safe clog2 and the default buffer parameters.
package tristate_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_t;

  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_PRIMITIVES = 1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set req bit at or above ptr,
// wrapping past N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = tristate_pkg::clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          vld,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Scan from the farthest offset down so the nearest hit wins.
  always_comb begin
    vld  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        vld = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/tristate_buffer.sv
// Enable-controlled tristate driver: q follows a while g is high, else hi-Z.
// PRIMITIVES selects gate-level bufif1 cells instead of a behavioural assign.
module tristate_buffer
  import tristate_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRIMITIVES = DEFAULT_PRIMITIVES
) (
  input  logic [WIDTH-1:0] a,
  input  logic             g,
  output wire  [WIDTH-1:0] q
);

  generate
    if (PRIMITIVES != 0) begin : g_prim
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        bufif1 u_buf (q[i], a[i], g);
      end
    end else begin : g_rtl
      assign q = g ? a : {WIDTH{1'bz}};
    end
  endgenerate

endmodule

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tristate bus, with hi-Z turnaround
// gaps between owners and a hold limit that forces release of long tenures.
module tristate_bus_arbiter
  import tristate_pkg::*;
#(
  parameter int N          = 4,
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int PRIMITIVES = DEFAULT_PRIMITIVES,
  parameter int TURNAROUND = 1,
  parameter int MAX_HOLD   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N-1:0]             req,
  input  logic [N*WIDTH-1:0]       din,
  output logic [N-1:0]             gnt,
  output logic [clog2(N)-1:0]      owner,
  output logic                     busy,
  output logic                     timeout,
  output wire  [WIDTH-1:0]         q
);

  localparam int OW = clog2(N);
  localparam int HW = clog2(MAX_HOLD + 1);
  localparam logic [2:0] TURN_LAST = 3'(TURNAROUND - 1);

  arb_state_t    state;
  logic [OW-1:0] ptr;
  logic [OW-1:0] next_ptr;
  logic [OW-1:0] pick_ptr;
  logic [OW-1:0] pick_idx;
  logic          pick_vld;
  logic [HW-1:0] hold;
  logic [2:0]    tcnt;
  logic          cut;
  logic          release_now;
  logic          arb_slot;
  logic          start;

  assign next_ptr    = (int'(owner) == N - 1) ? '0 : owner + OW'(1);
  assign cut         = req[owner] && (hold == HW'(MAX_HOLD - 1));
  assign release_now = !req[owner] || cut;

  // During a release the search must already start past the outgoing owner,
  // so a zero-length turnaround can re-arbitrate on the same edge.
  assign pick_ptr = (state == GRANT) ? next_ptr : ptr;

  assign arb_slot = (state == IDLE)
                 || ((state == TURN) && (tcnt == TURN_LAST))
                 || ((state == GRANT) && release_now && (TURNAROUND == 0));
  assign start    = arb_slot && pick_vld;

  rr_pick #(
    .N  (N),
    .IW (OW)
  ) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      timeout <= 1'b0;
      ptr     <= '0;
      hold    <= '0;
      tcnt    <= '0;
    end else begin
      timeout <= (state == GRANT) && cut;
      if ((state == GRANT) && release_now) ptr <= next_ptr;

      if (start) begin
        state <= GRANT;
        gnt   <= N'(1) << pick_idx;
        owner <= pick_idx;
        busy  <= 1'b1;
        hold  <= '0;
      end else begin
        case (state)
          IDLE: ;
          GRANT: begin
            if (release_now) begin
              gnt   <= '0;
              owner <= '0;
              busy  <= 1'b0;
              tcnt  <= '0;
              state <= (TURNAROUND == 0) ? IDLE : TURN;
            end else if (hold != '1) begin
              hold <= hold + HW'(1);
            end
          end
          TURN: begin
            if (tcnt == TURN_LAST) state <= IDLE;
            else                   tcnt  <= tcnt + 3'd1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Every driver shares q; only the granted buffer is ever enabled.
  generate
    for (genvar i = 0; i < N; i++) begin : g_buf
      tristate_buffer #(
        .WIDTH      (WIDTH),
        .PRIMITIVES (PRIMITIVES)
      ) u_buf (
        .a (din[i*WIDTH +: WIDTH]),
        .g (gnt[i]),
        .q (q)
      );
    end
  endgenerate

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Bench for tristate_bus_arbiter: directed scenarios plus random traffic
// compared against a tenure-level reference model.
module tb_tristate_bus_arbiter;

  localparam int N          = 4;
  localparam int WIDTH      = 8;
  localparam int TURNAROUND = 1;
  localparam int MAX_HOLD   = 16;
  localparam int OW         = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req = '0;
  logic [N*WIDTH-1:0]   din;
  wire  [N-1:0]         gnt;
  wire  [OW-1:0]        owner;
  wire                  busy;
  wire                  timeout;
  wire  [WIDTH-1:0]     q;

  // Weak stand-in for an idle bus: the bench drives zero only when no
  // owner is expected, so any DUT driver at that time disturbs the value.
  logic probe_en = 1'b1;
  assign q = probe_en ? {WIDTH{1'b0}} : {WIDTH{1'bz}};

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: current owner (-1 none), cycles held,
  // remaining gap cycles, round-robin start point, timeout flag.
  int   m_cur;
  int   m_held;
  int   m_gap;
  int   m_ptr;
  logic m_to;

  tristate_bus_arbiter #(
    .N          (N),
    .WIDTH      (WIDTH),
    .PRIMITIVES (1),
    .TURNAROUND (TURNAROUND),
    .MAX_HOLD   (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .din     (din),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy),
    .timeout (timeout),
    .q       (q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [WIDTH-1:0] slice(input int i);
    return din[i*WIDTH +: WIDTH];
  endfunction

  function automatic logic [N-1:0] exp_gnt();
    return (m_cur >= 0) ? (N'(1) << m_cur) : '0;
  endfunction

  function automatic logic [WIDTH-1:0] exp_q();
    return (m_cur >= 0) ? slice(m_cur) : '0;
  endfunction

  task automatic model_reset();
    m_cur  = -1;
    m_held = 0;
    m_gap  = 0;
    m_ptr  = 0;
    m_to   = 1'b0;
  endtask

  task automatic model_arb(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (r[c]) begin
        m_cur  = c;
        m_held = 0;
        return;
      end
    end
  endtask

  task automatic model_edge(input logic [N-1:0] r);
    m_to = 1'b0;
    if (m_cur >= 0) begin
      m_held++;
      if (!r[m_cur] || m_held == MAX_HOLD) begin
        m_to  = r[m_cur];
        m_ptr = (m_cur + 1) % N;
        m_cur = -1;
        m_gap = TURNAROUND;
        if (m_gap == 0) model_arb(r);
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) model_arb(r);
    end else begin
      model_arb(r);
    end
  endtask

  // One clock: apply req, step the model at the edge, sample at the negedge.
  task automatic tick(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    model_edge(r);
    #1;
    probe_en = (m_cur < 0);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst      = 1'b1;
    probe_en = 1'b1;
    req      = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 4'b1111;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_checks++;
    if (owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner: got %0d want 0", owner); end
    n_checks++;
    if (busy !== 1'b0 || timeout !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got busy=%b timeout=%b want 0 0", busy, timeout);
    end
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL reset_q: got %h want undriven (probe 00)", q); end
    apply_reset();
  endtask

  task automatic test_single();
    logic [N-1:0]     g_want;
    logic [WIDTH-1:0] q_want;
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      tick((c < 3) ? 4'b0001 : 4'b0000);
      g_want = (c < 3) ? 4'b0001 : 4'b0000;
      q_want = (c < 3) ? 8'hA5 : 8'h00;
      n_checks++;
      if (gnt !== g_want) begin n_fail++; $display("FAIL single_gnt[%0d]: got %b want %b", c, gnt, g_want); end
      n_checks++;
      if (q !== q_want) begin n_fail++; $display("FAIL single_q[%0d]: got %h want %h", c, q, q_want); end
      n_checks++;
      if (busy !== (c < 3)) begin n_fail++; $display("FAIL single_busy[%0d]: got %b want %b", c, busy, (c < 3)); end
    end
  endtask

  task automatic test_fairness();
    logic [N-1:0] fair_exp [13] = '{4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0,
                                    4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0};
    logic [N-1:0]     r;
    logic [WIDTH-1:0] q_want;
    int               cnt [N];
    apply_reset();
    r = 4'b1111;
    for (int i = 0; i < N; i++) cnt[i] = 0;
    for (int c = 0; c < 13; c++) begin
      tick(r);
      q_want = (fair_exp[c] != 0) ? slice($clog2(fair_exp[c])) : 8'h00;
      n_checks++;
      if (gnt !== fair_exp[c]) begin n_fail++; $display("FAIL fair_gnt[%0d]: got %b want %b", c, gnt, fair_exp[c]); end
      n_checks++;
      if (q !== q_want) begin n_fail++; $display("FAIL fair_q[%0d]: got %h want %h", c, q, q_want); end
      for (int i = 0; i < N; i++) begin
        if (fair_exp[c][i]) cnt[i]++;
        if (cnt[i] == 2) r[i] = 1'b0;
      end
    end
  endtask

  task automatic test_timeout();
    logic [N-1:0] r;
    logic [N-1:0] g_want;
    int           held1;
    apply_reset();
    held1 = 0;
    for (int c = 0; c < 22; c++) begin
      r    = '0;
      r[1] = (c < 20);
      r[2] = 1'b1;
      tick(r);
      g_want = (c < 16) ? 4'b0010 : (c == 16) ? 4'b0000 : 4'b0100;
      if (gnt[1]) held1++;
      n_checks++;
      if (gnt !== g_want) begin n_fail++; $display("FAIL timeout_gnt[%0d]: got %b want %b", c, gnt, g_want); end
      n_checks++;
      if (timeout !== (c == 16)) begin
        n_fail++; $display("FAIL timeout_pulse[%0d]: got %b want %b", c, timeout, (c == 16));
      end
    end
    n_checks++;
    if (held1 != MAX_HOLD) begin n_fail++; $display("FAIL timeout_tenure: got %0d cycles want %0d", held1, MAX_HOLD); end
    tick(4'b0000);
    tick(4'b0000);
  endtask

  task automatic test_handoff();
    apply_reset();
    tick(4'b0001);
    tick(4'b0001);
    n_checks++;
    if (gnt !== 4'b0001) begin n_fail++; $display("FAIL handoff_first: got %b want 0001", gnt); end
    tick(4'b1000);
    n_checks++;
    if (gnt !== 4'b0000 || q !== 8'h00) begin
      n_fail++; $display("FAIL handoff_gap: got gnt=%b q=%h want 0000 00", gnt, q);
    end
    tick(4'b1000);
    n_checks++;
    if (gnt !== 4'b1000 || owner !== 2'd3) begin
      n_fail++; $display("FAIL handoff_gnt: got gnt=%b owner=%0d want 1000 3", gnt, owner);
    end
    n_checks++;
    if (q !== 8'h3C) begin n_fail++; $display("FAIL handoff_q: got %h want 3c", q); end
    tick(4'b0000);
    tick(4'b0000);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    tick(4'b0010);
    tick(4'b0000);
    tick(4'b0100);
    n_checks++;
    if (gnt !== 4'b0100 || q !== 8'hC3) begin
      n_fail++; $display("FAIL midrst_pre: got gnt=%b q=%h want 0100 c3", gnt, q);
    end
    #2;
    rst      = 1'b1;
    probe_en = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0) begin
      n_fail++; $display("FAIL midrst_async: got gnt=%b busy=%b owner=%0d want 0000 0 0", gnt, busy, owner);
    end
    n_checks++;
    if (q !== 8'h00) begin n_fail++; $display("FAIL midrst_q: got %h want undriven (probe 00)", q); end
    @(negedge clk);
    rst = 1'b0;
    tick(4'b0101);
    n_checks++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      n_fail++; $display("FAIL midrst_ptr: got gnt=%b owner=%0d want 0001 0", gnt, owner);
    end
    tick(4'b0000);
    tick(4'b0000);
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] prev_g;
    apply_reset();
    r      = '0;
    prev_g = '0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(7) == 0) r[i] = ~r[i];
      end
      if ($urandom_range(15) == 0) begin
        for (int i = 0; i < N; i++) din[i*WIDTH +: WIDTH] = 8'($urandom_range(255, 1));
      end
      tick(r);
      n_checks++;
      if (gnt !== exp_gnt()) begin n_fail++; $display("FAIL rand_gnt[%0d]: got %b want %b", c, gnt, exp_gnt()); end
      n_checks++;
      if (owner !== OW'((m_cur >= 0) ? m_cur : 0) || busy !== (m_cur >= 0)) begin
        n_fail++; $display("FAIL rand_owner[%0d]: got owner=%0d busy=%b want %0d %b", c, owner, busy,
                           (m_cur >= 0) ? m_cur : 0, (m_cur >= 0));
      end
      n_checks++;
      if (timeout !== m_to) begin n_fail++; $display("FAIL rand_timeout[%0d]: got %b want %b", c, timeout, m_to); end
      n_checks++;
      if (q !== exp_q() || $isunknown(q)) begin n_fail++; $display("FAIL rand_q[%0d]: got %h want %h", c, q, exp_q()); end
      n_checks++;
      if ($countones(gnt) > 1) begin n_fail++; $display("FAIL rand_onehot[%0d]: got %b want at most one bit", c, gnt); end
      n_checks++;
      if (prev_g != 0 && gnt != 0 && gnt != prev_g) begin
        n_fail++; $display("FAIL rand_overlap[%0d]: got %b after %b want a hi-Z cycle between", c, gnt, prev_g);
      end
      prev_g = gnt;
    end
  endtask

  initial begin
    din = {8'h3C, 8'hC3, 8'h5A, 8'hA5};
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_handoff();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tristate_bus_arbiter.md
# tristate_bus_arbiter

Round-robin arbiter and drive-enable sequencer for a shared tristate data bus. It takes N requesters and grants bus ownership to at most one per cycle. It drives that requester's data onto the bus through per-requester `tristate_buffer` instances, and inserts idle (hi-Z) turnaround cycles between owners so that two drivers never overlap. It sits between the bus-master clients and the shared `q` net, and is the sole source of every buffer's `g` enable.

## Interface
Parameters:
- `N`, 4: number of requesters (2..16).
- `WIDTH`, 8: bus data width.
- `PRIMITIVES`, 1: passed unchanged to every `tristate_buffer` instance.
- `TURNAROUND`, 1: hi-Z cycles between ownership changes (0..7).
- `MAX_HOLD`, 16: maximum consecutive granted cycles per tenure (1..255).

Ports:
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input N: per-requester bus request, level.
- `din` input N*WIDTH: requester i data at bits [i*WIDTH +: WIDTH].
- `gnt` output N: one-hot-or-zero registered grant.
- `owner` output clog2(N): index of current owner; 0 when idle.
- `busy` output 1: 1 while any `gnt` bit is set.
- `timeout` output 1: one-cycle pulse when a tenure is cut by `MAX_HOLD`.
- `q` output WIDTH: shared bus; hi-Z when no grant.

## Operation
- FSM states are IDLE, GRANT and TURN.
- Reset (asynchronous, takes effect immediately, mid-tenure included):
  - state=IDLE;
  - `gnt`=0, `owner`=0, `busy`=0, `timeout`=0;
  - `q`=all-Z;
  - rr pointer=0;
  - hold counter=0.
- IDLE: if any `req` is set, select the first set bit searching from the rr pointer upward with wrap (pointer p, then p+1 ... N-1, 0 ... p-1). Go to GRANT, set `gnt[sel]`, `owner`=sel and hold=0.
- GRANT:
  - Each cycle, hold increments (saturating width clog2(MAX_HOLD+1)).
  - Release when `req[owner]`=0, or when hold reaches MAX_HOLD-1 while `req[owner]` is still 1. The latter case also pulses `timeout` in the first cycle after release.
  - On release: clear `gnt`, rr pointer=(owner+1) mod N, go to TURN. With TURNAROUND=0, re-arbitrate directly, i.e. behave as IDLE in the same edge.
- TURN:
  - Count TURNAROUND cycles with `gnt`=0.
  - On the edge ending the last TURN cycle, arbitrate as in IDLE. Go to GRANT if any request is present, else go to IDLE.
- Drive enable `g[i]`=`gnt[i]`. The data path is purely structural: `q` equals `din[owner]` while busy, and is hi-Z otherwise.
- Requests arriving or dropping during TURN are sampled only at arbitration.
- A requester cut off by timeout may keep `req` asserted. Round robin then serves others first, and the same requester is re-granted only if no other request is pending.

## Timing
- Grant latency: `req` seen high at edge t gives `gnt` high after edge t (visible cycle t+1) when the arbiter is in IDLE.
- Release latency: `req[owner]` low at edge t gives `gnt` low after edge t.
- Ownership gap: exactly TURNAROUND cycles of `q`=Z between owners; never 0 cycles of overlap.
- Maximum tenure is exactly MAX_HOLD cycles of `gnt` high.
- Worst-case wait for a continuously requesting client: (N-1)*(MAX_HOLD+TURNAROUND) cycles.
- `gnt` and `owner` are registered. `q` follows `gnt` combinationally through the buffers, with no extra cycle.
- `timeout` is registered and never coincides with `gnt` to the same owner.

## Structure
- Shared package `tristate_pkg`:
  - state enum (IDLE/GRANT/TURN);
  - `clog2` helper function;
  - default WIDTH/PRIMITIVES constants shared with `tristate_buffer`.
- Sub-module `rr_pick`: combinational round-robin priority selector (inputs req and pointer; outputs valid and index). It is reusable by other arbiters.
- Reuses the existing `tristate_buffer` (generate loop, N instances, all outputs tied to `q`).

## Test plan
- Single requester: N=4, `din[0]`=8'hA5, `req`=4'b0001 for 3 cycles. Expect `gnt`=0001 one cycle after `req`, `q`=8'hA5 for 3 cycles, then `q`=ZZZZZZZZ for 1 cycle, `busy`=0.
- All-request fairness: `req`=4'b1111 from reset, each requester drops its request after 2 granted cycles. Expect grant order 0,1,2,3, with exactly 1 Z cycle between each tenure.
- Timeout: `req[1]` held 20 cycles, `req[2]` high, MAX_HOLD=16. Expect `gnt[1]` exactly 16 cycles, a one-cycle `timeout` pulse, then `gnt[2]` after 1 turnaround cycle.
- Simultaneous hand-off: `req[0]` drops on the same edge `req[3]` rises. Expect `gnt`=0 for TURNAROUND cycles, then `gnt`=1000 and `q`=`din[3]`.
- Reset mid-tenure: assert `rst` while `gnt`=0100, between clock edges. Expect `gnt`=0 and `q`=Z immediately. After release with `req`=0001, expect `gnt`=0001 (pointer reset to 0).
- Continuous checks across random traffic, every cycle:
  - `$countones(gnt)`<=1;
  - `q` never X;
  - no cycle where `gnt` changes owner without an intervening Z cycle (TURNAROUND≥1).
